// File: rtl/gelato_types_pkg.sv
// Shared GELATO types: addresses, 3-D index triples and the dispatcher FSM encoding.
package gelato_types;

  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } int3_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_DONE
  } dispatch_state_t;

  function automatic logic int3_has_zero(input int3_t v);
    return (v.x == '0) || (v.y == '0) || (v.z == '0);
  endfunction

endpackage

// File: rtl/gelato_init_sm_if.sv
// Per-SM block-init channel: one valid strobe carrying the block's launch context.
interface gelato_init_sm_if;
  import gelato_types::*;

  logic  valid;
  addr_t pc;
  int3_t gridDim;
  int3_t blockDim;
  int3_t blockIdx;

  modport master (output valid, pc, gridDim, blockDim, blockIdx);
  modport slave  (input  valid, pc, gridDim, blockDim, blockIdx);

endinterface

// File: rtl/gelato_rr_arbiter.sv
// Round-robin arbiter: search starts at the slot after the last granted one.
module gelato_rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr_q) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

  always_comb begin
    if (idx_o == IW'(N - 1)) ptr_d = '0;
    else                     ptr_d = idx_o + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance_i && valid_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gelato_block_dispatcher.sv
// Kernel launcher: walks the grid x-major and hands each block to an idle SM,
// then waits for all SMs to drain before pulsing kernel_done.
module gelato_block_dispatcher
  import gelato_types::*;
#(
  parameter int unsigned NUM_SM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch_valid,
  output logic                  launch_ready,
  input  addr_t                 launch_pc,
  input  int3_t                 launch_grid_dim,
  input  int3_t                 launch_block_dim,
  gelato_init_sm_if.master      init_sm [NUM_SM],
  input  logic [NUM_SM-1:0]     sm_done,
  output logic                  kernel_done,
  output logic                  busy
);

  localparam int unsigned IW = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

  dispatch_state_t state_q, state_d;

  addr_t pc_q;
  int3_t grid_q;
  int3_t blkdim_q;
  int3_t idx_q;
  int3_t idx_d;

  logic [NUM_SM-1:0] sm_busy_q, sm_busy_d;
  logic [NUM_SM-1:0] valid_q;
  logic [NUM_SM-1:0] grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_any;
  logic              issue;
  logic              accept;
  logic              last_blk;
  logic              ready_q, busy_q, kdone_q;

  addr_t sm_pc_q     [NUM_SM];
  int3_t sm_grid_q   [NUM_SM];
  int3_t sm_blkdim_q [NUM_SM];
  int3_t sm_idx_q    [NUM_SM];

  gelato_rr_arbiter #(.N(NUM_SM)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (~sm_busy_q),
    .advance_i (issue),
    .grant_o   (grant),
    .idx_o     (grant_idx),
    .valid_o   (grant_any)
  );

  // ready_q resets high so the port reads 1 on the very first cycle after reset.
  assign launch_ready = ready_q & ~rst;
  assign kernel_done  = kdone_q;
  assign busy         = busy_q;

  assign accept   = launch_valid && launch_ready && (state_q == ST_IDLE);
  assign issue    = (state_q == ST_DISPATCH) && grant_any;
  assign last_blk = (idx_q.x == grid_q.x - 32'd1) &&
                    (idx_q.y == grid_q.y - 32'd1) &&
                    (idx_q.z == grid_q.z - 32'd1);

  always_comb begin
    idx_d = idx_q;
    if (idx_q.x == grid_q.x - 32'd1) begin
      idx_d.x = '0;
      if (idx_q.y == grid_q.y - 32'd1) begin
        idx_d.y = '0;
        idx_d.z = idx_q.z + 32'd1;
      end else begin
        idx_d.y = idx_q.y + 32'd1;
      end
    end else begin
      idx_d.x = idx_q.x + 32'd1;
    end
  end

  // A completion only frees the SM for the next cycle's arbitration.
  always_comb begin
    sm_busy_d = sm_busy_q & ~sm_done;
    if (issue) sm_busy_d = sm_busy_d | grant;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = int3_has_zero(launch_grid_dim) ? ST_DONE : ST_DISPATCH;
      ST_DISPATCH: if (issue && last_blk) state_d = ST_DRAIN;
      ST_DRAIN:    if (sm_busy_q == '0) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      kdone_q   <= 1'b0;
      sm_busy_q <= '0;
      valid_q   <= '0;
      pc_q      <= '0;
      grid_q    <= '0;
      blkdim_q  <= '0;
      idx_q     <= '0;
      for (int unsigned i = 0; i < NUM_SM; i++) begin
        sm_pc_q[i]     <= '0;
        sm_grid_q[i]   <= '0;
        sm_blkdim_q[i] <= '0;
        sm_idx_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
      kdone_q   <= (state_d == ST_DONE);
      sm_busy_q <= sm_busy_d;
      valid_q   <= issue ? grant : '0;
      if (accept) begin
        pc_q     <= launch_pc;
        grid_q   <= launch_grid_dim;
        blkdim_q <= launch_block_dim;
        idx_q    <= '0;
      end else if (issue) begin
        idx_q <= idx_d;
      end
      if (issue) begin
        sm_pc_q[grant_idx]     <= pc_q;
        sm_grid_q[grant_idx]   <= grid_q;
        sm_blkdim_q[grant_idx] <= blkdim_q;
        sm_idx_q[grant_idx]    <= idx_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    assign init_sm[g].valid    = valid_q[g];
    assign init_sm[g].pc       = sm_pc_q[g];
    assign init_sm[g].gridDim  = sm_grid_q[g];
    assign init_sm[g].blockDim = sm_blkdim_q[g];
    assign init_sm[g].blockIdx = sm_idx_q[g];
  end

endmodule

// File: tb/tb_gelato_block_dispatcher.sv
// Scoreboard bench for gelato_block_dispatcher with directed launches.
module tb_gelato_block_dispatcher;
  import gelato_types::*;

  localparam int unsigned NSM = 4;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     launch_valid = 1'b0;
  logic     launch_ready;
  addr_t    launch_pc = '0;
  int3_t    launch_grid_dim = '0;
  int3_t    launch_block_dim = '0;
  logic [NSM-1:0] sm_done;
  logic [NSM-1:0] sm_done_auto = '0;
  logic [NSM-1:0] sm_done_man = '0;
  logic     kernel_done;
  logic     busy;

  gelato_init_sm_if sm_if [NSM] ();

  assign sm_done = sm_done_auto | sm_done_man;

  gelato_block_dispatcher #(.NUM_SM(NSM)) dut (
    .clk              (clk),
    .rst              (rst),
    .launch_valid     (launch_valid),
    .launch_ready     (launch_ready),
    .launch_pc        (launch_pc),
    .launch_grid_dim  (launch_grid_dim),
    .launch_block_dim (launch_block_dim),
    .init_sm          (sm_if),
    .sm_done          (sm_done),
    .kernel_done      (kernel_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  logic [NSM-1:0] v;
  addr_t m_pc   [NSM];
  int3_t m_grid [NSM];
  int3_t m_blk  [NSM];
  int3_t m_idx  [NSM];

  for (genvar g = 0; g < NSM; g++) begin : g_tap
    assign v[g]      = sm_if[g].valid;
    assign m_pc[g]   = sm_if[g].pc;
    assign m_grid[g] = sm_if[g].gridDim;
    assign m_blk[g]  = sm_if[g].blockDim;
    assign m_idx[g]  = sm_if[g].blockIdx;
  end

  typedef struct {
    int    sm;
    int    cyc;
    addr_t pc;
    int3_t grid;
    int3_t blk;
    int3_t idx;
  } grant_t;

  grant_t exp_q[$];
  int     done_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     auto_dly = 0;
  int     done_at [NSM];
  int     c0, c1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int3_t i3(input int x, input int y, input int z);
    int3_t r;
    r.x = 32'(x);
    r.y = 32'(y);
    r.z = 32'(z);
    return r;
  endfunction

  task automatic push_grant(input int sm, input int c, input addr_t pc,
                            input int3_t grid, input int3_t blk, input int3_t idx);
    grant_t e;
    e.sm = sm; e.cyc = c; e.pc = pc; e.grid = grid; e.blk = blk; e.idx = idx;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Simulated SMs retire a block auto_dly cycles after its grant.
  always @(posedge clk) begin : sm_model
    #1;
    for (int g = 0; g < NSM; g++) sm_done_auto[g] = (done_at[g] == cyc);
  end

  logic [NSM-1:0] tbbusy = '0, clr1 = '0, clr2 = '0;

  always @(negedge clk) begin : monitor
    grant_t e;
    tbbusy = tbbusy & ~clr2;
    if (!$isunknown(v) && v != '0) chk("onehot_valid", 128'($onehot(v)), 128'(1));
    for (int g = 0; g < NSM; g++) begin
      if (v[g] === 1'b1) begin
        chk("grant_to_idle_sm", 128'(tbbusy[g]), 128'(0));
        tbbusy[g] = 1'b1;
        if (auto_dly > 0) done_at[g] = cyc + auto_dly;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: sm %0d blockIdx %0d,%0d,%0d at cycle %0d, none expected",
                   g, m_idx[g].x, m_idx[g].y, m_idx[g].z, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("grant_sm",       128'(g),         128'(e.sm));
          chk("grant_cycle",    128'(cyc),       128'(e.cyc));
          chk("grant_pc",       128'(m_pc[g]),   128'(e.pc));
          chk("grant_griddim",  128'(m_grid[g]), 128'(e.grid));
          chk("grant_blockdim", 128'(m_blk[g]),  128'(e.blk));
          chk("grant_blockidx", 128'(m_idx[g]),  128'(e.idx));
        end
      end
    end
    if (kernel_done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_kernel_done: got pulse at cycle %0d, none expected", cyc);
      end else begin
        chk("kernel_done_cycle", 128'(cyc), 128'(done_q.pop_front()));
      end
    end
    clr2 = clr1;
    clr1 = sm_done & tbbusy;
    if (rst) begin
      tbbusy = '0;
      clr1   = '0;
      clr2   = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    tick();
    rst          = 1'b1;
    launch_valid = 1'b0;
    sm_done_man  = '0;
    auto_dly     = 0;
    for (int g = 0; g < NSM; g++) done_at[g] = -1;
    @(negedge clk);
    chk("ready_in_reset", 128'(launch_ready), 128'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 128'(launch_ready), 128'(1));
    chk("busy_after_reset",  128'(busy),         128'(0));
    chk("kdone_after_reset", 128'(kernel_done),  128'(0));
    chk("valid_after_reset", 128'(v),            128'(0));
    for (int g = 0; g < NSM; g++)
      chk("fields_after_reset",
          128'(m_pc[g]) | 128'(m_grid[g]) | 128'(m_blk[g]) | 128'(m_idx[g]), 128'(0));
    chk("grants_outstanding", 128'(exp_q.size()),  128'(0));
    chk("done_outstanding",   128'(done_q.size()), 128'(0));
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic launch(input addr_t pc, input int3_t grid, input int3_t blk, output int c);
    tick();
    c = cyc;
    launch_valid     = 1'b1;
    launch_pc        = pc;
    launch_grid_dim  = grid;
    launch_block_dim = blk;
    @(negedge clk);
    chk("ready_at_launch", 128'(launch_ready), 128'(1));
    tick();
    launch_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int g = 0; g < NSM; g++) done_at[g] = -1;
    do_reset();

    // Two blocks, SMs never finish until a manual sm_done.
    launch(32'h1000, i3(2, 1, 1), i3(32, 1, 1), c0);
    push_grant(0, c0 + 2, 32'h1000, i3(2, 1, 1), i3(32, 1, 1), i3(0, 0, 0));
    push_grant(1, c0 + 3, 32'h1000, i3(2, 1, 1), i3(32, 1, 1), i3(1, 0, 0));
    done_q.push_back(c0 + 12);
    goto_cyc(c0 + 9);
    @(negedge clk);
    chk("drain_busy",  128'(busy),         128'(1));
    chk("drain_ready", 128'(launch_ready), 128'(0));
    goto_cyc(c0 + 10);
    sm_done_man = 4'b0011;
    tick();
    sm_done_man = '0;
    goto_cyc(c0 + 13);
    @(negedge clk);
    chk("ready_after_done", 128'(launch_ready), 128'(1));
    do_reset();

    // 3x2x2 grid, each SM retires 5 cycles after its grant.
    auto_dly = 5;
    launch(32'h2000, i3(3, 2, 2), i3(64, 2, 1), c0);
    for (int k = 0; k < 12; k++)
      push_grant(k % 4, c0 + 2 + (k / 4) * 7 + (k % 4), 32'h2000, i3(3, 2, 2), i3(64, 2, 1),
                 i3(k % 3, (k / 3) % 2, k / 6));
    done_q.push_back(c0 + 26);
    goto_cyc(c0 + 30);
    do_reset();

    // Zero-size grid: immediate completion, nothing issued.
    launch(32'h3000, i3(0, 4, 4), i3(1, 1, 1), c0);
    done_q.push_back(c0 + 1);
    goto_cyc(c0 + 2);
    @(negedge clk);
    chk("zero_grid_ready", 128'(launch_ready), 128'(1));
    chk("zero_grid_busy",  128'(busy),         128'(0));
    goto_cyc(c0 + 4);
    do_reset();

    // All SMs busy; freeing SM2 makes it grantable only two cycles later.
    launch(32'h4000, i3(8, 1, 1), i3(16, 1, 1), c0);
    for (int k = 0; k < 4; k++)
      push_grant(k, c0 + 2 + k, 32'h4000, i3(8, 1, 1), i3(16, 1, 1), i3(k, 0, 0));
    push_grant(2, c0 + 10, 32'h4000, i3(8, 1, 1), i3(16, 1, 1), i3(4, 0, 0));
    goto_cyc(c0 + 8);
    sm_done_man = 4'b0100;
    tick();
    sm_done_man = '0;
    goto_cyc(c0 + 12);
    do_reset();

    // Reset in the middle of dispatch, then a fresh launch restarts at (0,0,0).
    launch(32'h5000, i3(8, 1, 1), i3(16, 1, 1), c0);
    for (int k = 0; k < 3; k++)
      push_grant(k, c0 + 2 + k, 32'h5000, i3(8, 1, 1), i3(16, 1, 1), i3(k, 0, 0));
    goto_cyc(c0 + 3);
    do_reset();
    auto_dly = 3;
    launch(32'h5100, i3(1, 1, 1), i3(8, 8, 1), c1);
    push_grant(0, c1 + 2, 32'h5100, i3(1, 1, 1), i3(8, 8, 1), i3(0, 0, 0));
    done_q.push_back(c1 + 7);
    goto_cyc(c1 + 9);
    do_reset();

    // launch_valid held high through DRAIN with changed fields.
    auto_dly = 4;
    tick();
    c0 = cyc;
    launch_valid     = 1'b1;
    launch_pc        = 32'h6000;
    launch_grid_dim  = i3(1, 1, 1);
    launch_block_dim = i3(4, 1, 1);
    push_grant(0, c0 + 2, 32'h6000, i3(1, 1, 1), i3(4, 1, 1), i3(0, 0, 0));
    done_q.push_back(c0 + 8);
    push_grant(1, c0 + 11, 32'h6100, i3(2, 1, 1), i3(2, 2, 2), i3(0, 0, 0));
    push_grant(2, c0 + 12, 32'h6100, i3(2, 1, 1), i3(2, 2, 2), i3(1, 0, 0));
    done_q.push_back(c0 + 18);
    tick();
    launch_pc        = 32'h6100;
    launch_grid_dim  = i3(2, 1, 1);
    launch_block_dim = i3(2, 2, 2);
    goto_cyc(c0 + 5);
    @(negedge clk);
    chk("held_valid_ready_drain", 128'(launch_ready), 128'(0));
    goto_cyc(c0 + 9);
    @(negedge clk);
    chk("held_valid_ready_back", 128'(launch_ready), 128'(1));
    goto_cyc(c0 + 10);
    launch_valid = 1'b0;
    goto_cyc(c0 + 21);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
